// File: rtl/led_scan_pkg.sv
// Shared types and constants for the row-multiplexed LED matrix driver.
// Default geometry and timing are also used by the game modules feeding it.
package led_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int LED_ROWS  = 8;
  localparam int LED_COLS  = 8;
  localparam int LED_DWELL = 1024;
  localparam int LED_BLANK = 16;

  // Physical pin level for a logical "on" (1) or "off" (0).
  function automatic logic drv(input bit value, input bit active_low);
    return value ^ active_low;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row scan sequencer: BLANK/SHOW state, dwell/blank counter and row index.
// frame_start is registered so it lines up with the first BLANK cycle of row 0.
module scan_timer
  import led_scan_pkg::*;
#(
  parameter int  ROWS  = LED_ROWS,
  parameter int  DWELL = LED_DWELL,
  parameter int  BLANK = LED_BLANK,
  localparam int RW    = $clog2(ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [RW-1:0] row_o,
  output scan_state_t   state_o,
  output logic          last_blank_o,
  output logic          last_show_o,
  output logic          last_show_of_frame_o,
  output logic          frame_start_o
);

  localparam int CW = $clog2(((DWELL > BLANK) ? DWELL : BLANK) + 1);

  scan_state_t   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_start_q;
  logic          last_blank, last_show, last_frame;

  always_comb begin
    last_blank = (state_q == ST_BLANK) && (cnt_q == CW'(BLANK - 1));
    last_show  = (state_q == ST_SHOW)  && (cnt_q == CW'(DWELL - 1));
    last_frame = last_show && (row_q == RW'(ROWS - 1));
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q + 1'b1;
    if (last_blank) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
    end else if (last_show) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      row_d   = last_frame ? '0 : row_q + 1'b1;
    end
  end

  // Reset lands on the first BLANK cycle of row 0, so frame_start comes out high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_BLANK;
      row_q         <= '0;
      cnt_q         <= '0;
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      frame_start_q <= last_frame;
    end
  end

  assign row_o                = row_q;
  assign state_o              = state_q;
  assign last_blank_o         = last_blank;
  assign last_show_o          = last_show;
  assign last_show_of_frame_o = last_frame;
  assign frame_start_o        = frame_start_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered ROWS x COLS LED matrix driver; banks swap only at frame boundaries.
// Writes go to the back bank; column data is latched per row so a SHOW never tears.
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int  ROWS           = LED_ROWS,
  parameter int  COLS           = LED_COLS,
  parameter int  DWELL          = LED_DWELL,
  parameter int  BLANK          = LED_BLANK,
  parameter bit  COL_ACTIVE_LOW = 1'b1,
  parameter bit  ROW_ACTIVE_LOW = 1'b0,
  localparam int RW             = $clog2(ROWS)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [ROWS-1:0] row_drv,
  output logic [COLS-1:0] col_drv
);

  logic [RW-1:0] row;
  scan_state_t   state;
  logic          last_blank, last_show, last_frame;

  scan_timer #(
    .ROWS  (ROWS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_timer (
    .clk_i                (CLK),
    .rst_i                (rst),
    .row_o                (row),
    .state_o              (state),
    .last_blank_o         (last_blank),
    .last_show_o          (last_show),
    .last_show_of_frame_o (last_frame),
    .frame_start_o        (frame_start)
  );

  logic [COLS-1:0] bank_q [2][ROWS];
  logic            front_q, front_d;
  logic            swap_ack_q, swap_ack_d;
  logic [ROWS-1:0] row_drv_q, row_drv_d, row_on;
  logic [COLS-1:0] col_drv_q, col_drv_d, col_on, front_row;

  always_comb begin
    front_row = bank_q[front_q][row];
    for (int r = 0; r < ROWS; r++) row_on[r] = drv(row == RW'(r), ROW_ACTIVE_LOW);
    for (int c = 0; c < COLS; c++) col_on[c] = drv(front_row[c], COL_ACTIVE_LOW);
    row_drv_d  = {ROWS{ROW_ACTIVE_LOW}};
    col_drv_d  = {COLS{COL_ACTIVE_LOW}};
    front_d    = front_q;
    swap_ack_d = 1'b0;
    if (last_blank) begin
      row_drv_d = row_on;
      col_drv_d = col_on;
    end else if ((state == ST_SHOW) && !last_show) begin
      row_drv_d = row_drv_q;
      col_drv_d = col_drv_q;
    end
    if (last_frame && swap_req) begin
      front_d    = ~front_q;
      swap_ack_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      front_q    <= 1'b0;
      swap_ack_q <= 1'b0;
      row_drv_q  <= {ROWS{ROW_ACTIVE_LOW}};
      col_drv_q  <= {COLS{COL_ACTIVE_LOW}};
    end else begin
      front_q    <= front_d;
      swap_ack_q <= swap_ack_d;
      row_drv_q  <= row_drv_d;
      col_drv_q  <= col_drv_d;
    end
  end

  // Back bank is selected from front_q before any same-cycle swap takes effect.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) bank_q[b][r] <= '0;
    end else if (wr_en && (int'(wr_row) < ROWS)) begin
      bank_q[~front_q][wr_row] <= wr_data;
    end
  end

  assign swap_ack = swap_ack_q;
  assign row_drv  = row_drv_q;
  assign col_drv  = col_drv_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: 8x8, DWELL=4, BLANK=2 (6-cycle slot, 48-cycle frame).
// A second 6-row instance shares the inputs so an out-of-range row index is expressible.
module tb_led_matrix_scan;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;

  logic       swap_ack, frame_start;
  logic [7:0] row_drv, col_drv;
  logic       d6_swap_ack, d6_frame_start;
  logic [5:0] d6_row_drv;
  logic [7:0] d6_col_drv;

  int checks = 0;
  int errors = 0;
  int off    = 0;

  always #5 CLK = ~CLK;

  led_matrix_scan #(
    .ROWS(8), .COLS(8), .DWELL(4), .BLANK(2), .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b0)
  ) dut (
    .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .row_drv(row_drv), .col_drv(col_drv)
  );

  led_matrix_scan #(
    .ROWS(6), .COLS(8), .DWELL(4), .BLANK(2), .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b0)
  ) dut6 (
    .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(d6_swap_ack), .frame_start(d6_frame_start),
    .row_drv(d6_row_drv), .col_drv(d6_col_drv)
  );

  function automatic bit show_at(int o);
    return (o % 6) >= 2;
  endfunction

  function automatic int row_at(int o, int rows);
    return (o / 6) % rows;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    off++;
  endtask

  // Leaves the bench in the first cycle after release: frame offset 0.
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    off = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (row_drv !== 8'h00) begin errors++; $display("FAIL rst_row got %h exp 00", row_drv); end
    checks++; if (col_drv !== 8'hFF) begin errors++; $display("FAIL rst_col got %h exp ff", col_drv); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", swap_ack); end
    do_reset();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rel_fs got %b exp 1", frame_start); end
    checks++; if (row_drv !== 8'h00) begin errors++; $display("FAIL rel_row got %h exp 00", row_drv); end
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_pulse got %b exp 0", frame_start); end
  endtask

  task automatic test_idle();
    logic [7:0] er;
    do_reset();
    for (int i = 0; i <= 48; i++) begin
      er = 8'h00;
      if (show_at(off)) er[row_at(off, 8)] = 1'b1;
      checks++; if (row_drv !== er) begin errors++; $display("FAIL idle_row off=%0d got %h exp %h", off, row_drv, er); end
      checks++; if (col_drv !== 8'hFF) begin errors++; $display("FAIL idle_col off=%0d got %h exp ff", off, col_drv); end
      checks++; if (frame_start !== (off % 48 == 0)) begin errors++; $display("FAIL idle_fs off=%0d got %b", off, frame_start); end
      if (i < 48) tick();
    end
  endtask

  task automatic test_write_swap();
    logic [7:0] ec;
    do_reset();
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    while (off <= 95) begin
      ec = (off >= 48 && show_at(off) && row_at(off, 8) == 3) ? 8'h5A : 8'hFF;
      checks++; if (col_drv !== ec) begin errors++; $display("FAIL ws_col off=%0d got %h exp %h", off, col_drv, ec); end
      checks++; if (swap_ack !== (off == 48)) begin errors++; $display("FAIL ws_ack off=%0d got %b", off, swap_ack); end
      if (off == 10) swap_req = 1'b1;
      if (off == 48) swap_req = 1'b0;
      tick();
    end
  endtask

  // Continues from test_write_swap: front holds row 3 = A5, back is all zero.
  task automatic test_write_during_show();
    logic [7:0] ec;
    while (off <= 191) begin
      ec = 8'hFF;
      if (show_at(off) && row_at(off, 8) == 3) ec = (off < 144) ? 8'h5A : 8'hF0;
      checks++; if (col_drv !== ec) begin errors++; $display("FAIL wds_col off=%0d got %h exp %h", off, col_drv, ec); end
      checks++; if (swap_ack !== (off == 144)) begin errors++; $display("FAIL wds_ack off=%0d got %b", off, swap_ack); end
      wr_en = (off == 117);
      wr_row = 3'd3; wr_data = 8'h0F;
      if (off == 130) swap_req = 1'b1;
      if (off == 144) swap_req = 1'b0;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Row 9 does not fit in a 3-bit index; rows 6 and 7 are out of range for the 6-row instance.
  task automatic test_bad_row();
    logic [5:0] er;
    do_reset();
    wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'hFF;
    tick();
    wr_row = 3'd6;
    tick();
    wr_en = 1'b0; swap_req = 1'b1;
    while (off <= 71) begin
      er = 6'h00;
      if (show_at(off)) er[row_at(off, 6)] = 1'b1;
      checks++; if (d6_col_drv !== 8'hFF) begin errors++; $display("FAIL bad_col off=%0d got %h exp ff", off, d6_col_drv); end
      checks++; if (d6_row_drv !== er) begin errors++; $display("FAIL bad_row off=%0d got %h exp %h", off, d6_row_drv, er); end
      checks++; if (d6_swap_ack !== (off == 36)) begin errors++; $display("FAIL bad_ack off=%0d got %b", off, d6_swap_ack); end
      if (off == 36) swap_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ec;
    do_reset();
    while (off <= 53) begin
      ec = (off >= 50 && show_at(off) && row_at(off, 8) == 0) ? 8'hFE : 8'hFF;
      checks++; if (col_drv !== ec) begin errors++; $display("FAIL b2b_col off=%0d got %h exp %h", off, col_drv, ec); end
      checks++; if (swap_ack !== (off == 48)) begin errors++; $display("FAIL b2b_ack off=%0d got %b", off, swap_ack); end
      if (off == 48) begin
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_fs got %b exp 1", frame_start); end
      end
      swap_req = (off == 47);
      wr_en = (off == 47);
      wr_row = 3'd0; wr_data = 8'h01;
      tick();
    end
    wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1; wr_row = 3'd5; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    while (off < 47) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    while (off < 81) tick();
    checks++; if (col_drv !== 8'h00) begin errors++; $display("FAIL mid_lit got %h exp 00", col_drv); end
    checks++; if (row_drv !== 8'h20) begin errors++; $display("FAIL mid_row got %h exp 20", row_drv); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    off = 0;
    checks++; if (row_drv !== 8'h00) begin errors++; $display("FAIL mid_rst_row got %h exp 00", row_drv); end
    checks++; if (col_drv !== 8'hFF) begin errors++; $display("FAIL mid_rst_col got %h exp ff", col_drv); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_rst_fs got %b exp 1", frame_start); end
    swap_req = 1'b1;
    while (off <= 83) begin
      checks++; if (col_drv !== 8'hFF) begin errors++; $display("FAIL mid_clr off=%0d got %h exp ff", off, col_drv); end
      checks++; if (swap_ack !== (off == 48)) begin errors++; $display("FAIL mid_ack off=%0d got %b", off, swap_ack); end
      if (off == 48) swap_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write_swap();
    test_write_during_show();
    test_bad_row();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
